// File: rtl/digital_clock.sv
// Digital alarm clock: BCD HH:MM time and alarm, set/show FSM, four-digit 7-segment output.
// Define LEADING_ZERO_BLANK_EN to blank the hours-tens digit when it is zero.
module digital_clock #(
    parameter int HALF_SEC_CYCLES   = 25000000,
    parameter int HALF_SECS_PER_MIN = 120
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        showAlarmIn,
    input  logic        minutesIn,
    input  logic        hoursIn,
    input  logic        enAlarmIn,
    output logic        soundAlarm,
    output logic [27:0] disp7Seg
);

    typedef enum logic [1:0] {SHOW_TIME, SET_TIME, SHOW_ALARM, SET_ALARM} state_t;

    localparam int HalfW = (HALF_SEC_CYCLES > 1) ? $clog2(HALF_SEC_CYCLES) : 1;
    localparam int MinW  = (HALF_SECS_PER_MIN > 1) ? $clog2(HALF_SECS_PER_MIN) : 1;
    localparam logic [HalfW-1:0] HalfLast = HalfW'(HALF_SEC_CYCLES - 1);
    localparam logic [MinW-1:0]  MinLast  = MinW'(HALF_SECS_PER_MIN - 1);

    state_t           state_q, state_d;
    logic [HalfW-1:0] halfCnt_q, halfCnt_d;
    logic [MinW-1:0]  minCnt_q, minCnt_d;
    logic [15:0]      time_q, time_d;
    logic [15:0]      alarm_q, alarm_d;
    logic [15:0]      setReg_q, setReg_d;
    logic [15:0]      setBase;
    logic [15:0]      dispSrc;
    logic             halfTick, minTick, inSet, entering;

    function automatic logic [7:0] incMinutes(input logic [7:0] m);
        logic [7:0] r;
        if (m[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (m[7:4] == 4'd5) ? 4'd0 : m[7:4] + 4'd1;
        end else begin
            r[7:4] = m[7:4];
            r[3:0] = m[3:0] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] incHours(input logic [7:0] h);
        logic [7:0] r;
        if (h == 8'h23) begin
            r = 8'h00;
        end else if (h[3:0] == 4'd9) begin
            r = {h[7:4] + 4'd1, 4'd0};
        end else begin
            r = {h[7:4], h[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Mode is a pure function of the current inputs; state_q only serves to detect entry
    // into a set mode and to pick the display source.
    always_comb begin
        state_d = SHOW_TIME;
        if (showAlarmIn) begin
            state_d = (hoursIn || minutesIn) ? SET_ALARM : SHOW_ALARM;
        end else begin
            state_d = (hoursIn || minutesIn) ? SET_TIME : SHOW_TIME;
        end
    end

    always_comb begin
        halfTick  = (halfCnt_q == HalfLast);
        minTick   = halfTick && (minCnt_q == MinLast);
        halfCnt_d = halfTick ? '0 : halfCnt_q + HalfW'(1);

        minCnt_d = minCnt_q;
        if (halfTick) begin
            minCnt_d = minTick ? '0 : minCnt_q + MinW'(1);
        end
        if (state_d == SET_TIME) begin
            minCnt_d = '0;
        end

        inSet    = (state_d == SET_TIME) || (state_d == SET_ALARM);
        entering = inSet && (state_d != state_q);

        setBase = setReg_q;
        if (entering) begin
            setBase = (state_d == SET_TIME) ? time_q : alarm_q;
        end
        setReg_d = setBase;
        if (inSet && halfTick) begin
            if (hoursIn) begin
                setReg_d = {incHours(setBase[15:8]), setBase[7:0]};
            end else begin
                setReg_d = {setBase[15:8], incMinutes(setBase[7:0])};
            end
        end

        time_d = time_q;
        if (state_d == SET_TIME) begin
            time_d = setReg_d;
        end else if (minTick) begin
            if (time_q[7:0] == 8'h59) begin
                time_d = {incHours(time_q[15:8]), 8'h00};
            end else begin
                time_d = {time_q[15:8], incMinutes(time_q[7:0])};
            end
        end

        alarm_d = (state_d == SET_ALARM) ? setReg_d : alarm_q;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q   <= SHOW_TIME;
            halfCnt_q <= '0;
            minCnt_q  <= '0;
            time_q    <= 16'h0000;
            alarm_q   <= 16'h0600;
            setReg_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            halfCnt_q <= halfCnt_d;
            minCnt_q  <= minCnt_d;
            time_q    <= time_d;
            alarm_q   <= alarm_d;
            setReg_q  <= setReg_d;
        end
    end

    always_comb begin
        case (state_q)
            SHOW_ALARM, SET_ALARM: dispSrc = alarm_q;
            SET_TIME:              dispSrc = setReg_q;
            default:               dispSrc = time_q;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        disp7Seg[27:21] = (dispSrc[15:12] == 4'd0) ? 7'b0000000 : seg7(dispSrc[15:12]);
`else
        disp7Seg[27:21] = seg7(dispSrc[15:12]);
`endif
        disp7Seg[20:14] = seg7(dispSrc[11:8]);
        disp7Seg[13:7]  = seg7(dispSrc[7:4]);
        disp7Seg[6:0]   = seg7(dispSrc[3:0]);
        soundAlarm      = enAlarmIn && (time_q == alarm_q);
    end

endmodule

// File: tb/tb_digital_clock.sv
// Directed bench for digital_clock with short prescalers (2 cycles/half-second, 2 half-seconds/minute).
// Expected display/alarm values are queued when stimulus is driven and checked when sampled.
module tb_digital_clock;

    logic        sysclk;
    logic        reset;
    logic        showAlarmIn;
    logic        minutesIn;
    logic        hoursIn;
    logic        enAlarmIn;
    logic        soundAlarm;
    logic [27:0] disp7Seg;

    typedef struct {
        string       tag;
        logic [27:0] disp;
        logic        snd;
    } exp_t;

    exp_t sb[$];
    int   passCount = 0;
    int   checkCount = 0;

    logic [6:0] segTbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    digital_clock #(
        .HALF_SEC_CYCLES  (2),
        .HALF_SECS_PER_MIN(2)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .showAlarmIn(showAlarmIn),
        .minutesIn  (minutesIn),
        .hoursIn    (hoursIn),
        .enAlarmIn  (enAlarmIn),
        .soundAlarm (soundAlarm),
        .disp7Seg   (disp7Seg)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    function automatic logic [27:0] encDisp(input logic [15:0] hhmm);
        logic [6:0] tens;
        tens = segTbl[hhmm[15:12]];
`ifdef LEADING_ZERO_BLANK_EN
        if (hhmm[15:12] == 4'd0) tens = 7'b0000000;
`endif
        return {tens, segTbl[hhmm[11:8]], segTbl[hhmm[7:4]], segTbl[hhmm[3:0]]};
    endfunction

    task automatic applyStimulus(input logic show, input logic hrs, input logic mins, input logic en);
        showAlarmIn = show;
        hoursIn     = hrs;
        minutesIn   = mins;
        enAlarmIn   = en;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Holding buttons from just after a half-tick edge spans exactly 'ticks' half-second ticks.
    task automatic holdButtons(input logic hrs, input logic mins, input int ticks);
        hoursIn   = hrs;
        minutesIn = mins;
        waitEdges(2 * ticks);
    endtask

    task automatic expectState(input string tag, input logic [15:0] hhmm, input logic snd);
        exp_t e;
        e.tag  = tag;
        e.disp = encDisp(hhmm);
        e.snd  = snd;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        e = sb.pop_front();
        checkCount++;
        assert (disp7Seg === e.disp) passCount++;
        else $error("[TB] FAIL %s disp7Seg got %b want %b", e.tag, disp7Seg, e.disp);
        checkCount++;
        assert (soundAlarm === e.snd) passCount++;
        else $error("[TB] FAIL %s soundAlarm got %b want %b", e.tag, soundAlarm, e.snd);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectState("reset", 16'h0000, 1'b0);
        waitEdges(2);
        checkOutput();
        @(negedge sysclk);
        reset = 1'b0;

        expectState("idle_3cyc", 16'h0000, 1'b0);
        waitEdges(3);
        checkOutput();
        expectState("idle_4cyc", 16'h0001, 1'b0);
        waitEdges(1);
        checkOutput();

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expectState("show_alarm", 16'h0600, 1'b0);
        waitEdges(2);
        checkOutput();
        expectState("alarm_hr_1tick", 16'h0700, 1'b0);
        holdButtons(1'b1, 1'b0, 1);
        checkOutput();
        expectState("alarm_hr_3tick", 16'h0900, 1'b0);
        holdButtons(1'b1, 1'b0, 2);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectState("time_kept_counting", 16'h0003, 1'b0);
        waitEdges(2);
        checkOutput();

        expectState("time_0058", 16'h0058, 1'b0);
        waitEdges(218);
        checkOutput();
        expectState("set_min_0059", 16'h0059, 1'b0);
        holdButtons(1'b0, 1'b1, 1);
        checkOutput();
        expectState("set_min_wrap", 16'h0000, 1'b0);
        holdButtons(1'b0, 1'b1, 1);
        checkOutput();
        expectState("set_min_0001", 16'h0001, 1'b0);
        holdButtons(1'b0, 1'b1, 1);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectState("release_shows", 16'h0001, 1'b0);
        waitEdges(1);
        checkOutput();
        expectState("prescale_restart", 16'h0001, 1'b0);
        waitEdges(2);
        checkOutput();
        expectState("first_min_after_set", 16'h0002, 1'b0);
        waitEdges(1);
        checkOutput();

        expectState("set_to_0030", 16'h0030, 1'b0);
        holdButtons(1'b0, 1'b1, 28);
        checkOutput();
        expectState("set_to_2230", 16'h2230, 1'b0);
        holdButtons(1'b1, 1'b0, 22);
        checkOutput();
        expectState("both_btn_1tick", 16'h2330, 1'b0);
        holdButtons(1'b1, 1'b1, 1);
        checkOutput();
        expectState("both_btn_hr_wrap", 16'h0030, 1'b0);
        holdButtons(1'b1, 1'b1, 1);
        checkOutput();
        expectState("set_to_2330", 16'h2330, 1'b0);
        holdButtons(1'b1, 1'b0, 23);
        checkOutput();
        expectState("set_to_2359", 16'h2359, 1'b0);
        holdButtons(1'b0, 1'b1, 29);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectState("before_rollover", 16'h2359, 1'b0);
        waitEdges(3);
        checkOutput();
        expectState("rollover_0000", 16'h0000, 1'b0);
        waitEdges(1);
        checkOutput();

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        expectState("alarm_hr_wrap", 16'h0000, 1'b0);
        holdButtons(1'b1, 1'b0, 15);
        checkOutput();
        expectState("alarm_0002", 16'h0002, 1'b0);
        holdButtons(1'b0, 1'b1, 2);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        expectState("time_set_0001", 16'h0001, 1'b0);
        holdButtons(1'b0, 1'b1, 53);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectState("enable_no_match", 16'h0001, 1'b0);
        #1;
        checkOutput();
        expectState("before_match", 16'h0001, 1'b0);
        waitEdges(3);
        checkOutput();
        expectState("alarm_sounds", 16'h0002, 1'b1);
        waitEdges(1);
        checkOutput();
        expectState("alarm_holds_minute", 16'h0002, 1'b1);
        waitEdges(3);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectState("disable_immediate", 16'h0002, 1'b0);
        #1;
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectState("match_ends", 16'h0003, 1'b0);
        waitEdges(1);
        checkOutput();

        expectState("mid_set_0005", 16'h0005, 1'b0);
        holdButtons(1'b0, 1'b1, 2);
        checkOutput();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectState("reset_mid_set", 16'h0000, 1'b0);
        #1;
        checkOutput();
        @(negedge sysclk);
        reset = 1'b0;
        expectState("post_reset_time", 16'h0000, 1'b0);
        waitEdges(3);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        expectState("post_reset_alarm", 16'h0600, 1'b0);
        waitEdges(1);
        checkOutput();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
